// File: rtl/pcie_rst_seq.sv
// rtl/pcie_rst_seq.sv - PCIe/system reset sequencer with PLL-lock qualification and staggered release
// Optional feature macro: RST_SEQ_LOCK_STATS_EN (saturating lock-loss counter on lock_loss_cnt)
module pcie_rst_seq #(
  parameter int HOLD_CYCLES         = 200,
  parameter int SETTLE_CYCLES       = 16,
  parameter int STAGGER_CYCLES      = 8,
  parameter int LOCK_TIMEOUT_CYCLES = 10000,
  parameter int CNT_W               = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_locked,
  input  logic             sw_reset_req,
  output logic             pcie_reset_n,
  output logic             sys_reset_n,
  output logic [2:0]       seq_state,
  output logic             timeout_err,
  output logic [CNT_W-1:0] lock_loss_cnt
);

  localparam int MAX_A = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
  localparam int MAX_B = (STAGGER_CYCLES > LOCK_TIMEOUT_CYCLES) ? STAGGER_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAX_P) + 1;

  localparam logic [2:0] S_HOLD      = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_SETTLE    = 3'd2;
  localparam logic [2:0] S_PCIE_REL  = 3'd3;
  localparam logic [2:0] S_RUN       = 3'd4;
  localparam logic [2:0] S_FAULT     = 3'd5;

  logic          sync1;
  logic          lock_s;
  logic [2:0]    state;
  logic [2:0]    next_state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] cnt_next;
  logic          timeout_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= pll_locked;
      lock_s <= sync1;
    end
  end

  assign cnt_inc = cnt + 1'b1;

  // One shared counter: every state transition clears it, so each state times its own dwell.
  always_comb begin
    next_state  = state;
    cnt_next    = cnt_inc;
    timeout_hit = 1'b0;
    if (sw_reset_req) begin
      next_state = S_HOLD;
      cnt_next   = '0;
    end else begin
      case (state)
        S_HOLD: begin
          if (cnt_inc == CW'(HOLD_CYCLES)) begin
            next_state = S_WAIT_LOCK;
            cnt_next   = '0;
          end
        end
        S_WAIT_LOCK: begin
          if (lock_s) begin
            next_state = S_SETTLE;
            cnt_next   = '0;
          end else if (cnt_inc == CW'(LOCK_TIMEOUT_CYCLES)) begin
            next_state  = S_FAULT;
            cnt_next    = '0;
            timeout_hit = 1'b1;
          end
        end
        S_SETTLE: begin
          if (!lock_s) begin
            next_state = S_WAIT_LOCK;
            cnt_next   = '0;
          end else if (cnt_inc == CW'(SETTLE_CYCLES)) begin
            next_state = S_PCIE_REL;
            cnt_next   = '0;
          end
        end
        S_PCIE_REL: begin
          if (!lock_s) begin
            next_state = S_HOLD;
            cnt_next   = '0;
          end else if (cnt_inc == CW'(STAGGER_CYCLES)) begin
            next_state = S_RUN;
            cnt_next   = '0;
          end
        end
        S_RUN: begin
          cnt_next = '0;
          if (!lock_s) next_state = S_HOLD;
        end
        S_FAULT: cnt_next = '0;
        default: begin
          next_state = S_HOLD;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Resets are decoded from next_state so they move on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_HOLD;
      cnt          <= '0;
      pcie_reset_n <= 1'b0;
      sys_reset_n  <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= next_state;
      cnt          <= cnt_next;
      pcie_reset_n <= (next_state == S_PCIE_REL) || (next_state == S_RUN);
      sys_reset_n  <= (next_state == S_RUN);
      if (sw_reset_req)     timeout_err <= 1'b0;
      else if (timeout_hit) timeout_err <= 1'b1;
    end
  end

  assign seq_state = state;

`ifdef RST_SEQ_LOCK_STATS_EN
  // Loss of lock after release always returns to HOLD, with or without a coincident sw request.
  logic             lock_loss;
  logic [CNT_W-1:0] loss_q;

  assign lock_loss = !lock_s && ((state == S_PCIE_REL) || (state == S_RUN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_q <= '0;
    end else if (lock_loss && (loss_q != {CNT_W{1'b1}})) begin
      loss_q <= loss_q + 1'b1;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n && lock_loss) $display("pcie_rst_seq: PLL lock lost in state %0d", state);
  end
`endif

  assign lock_loss_cnt = loss_q;
`else
  assign lock_loss_cnt = '0;
`endif

endmodule
